// File: rtl/cavlc_bit_window.sv
// ----------------------------------------------------------------------------
// cavlc_bit_window
//   Bit alignment stage in front of the CAVLC coeff_token LUTs. Incoming
//   WORD_W-bit stream words are packed MSB-first into a 2*WORD_W-bit buffer.
//   The top WIN_W bits are presented as the lookup window. The LUT's NumShift
//   value advances the bit pointer. Flush and byte-align operations support
//   slice and syntax boundaries.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_word_in      next stream word, MSB = earliest bit
//   i_word_valid   i_word_in valid
//   o_word_ready   buffer can take a word this cycle (Fill <= WORD_W, no flush)
//   o_window       next WIN_W unconsumed bits, MSB = next bit
//   o_window_valid Fill >= WIN_W
//   i_shift_en     consume i_shift_amt bits this cycle
//   i_shift_amt    bits to consume, 0..WIN_W
//   i_flush        discard all buffered bits, clear bit position
//   i_align_req    discard bits up to the next byte boundary
//   o_bit_pos      bits consumed since reset/flush (wraps)
//   o_fill         valid bits currently buffered
//   o_err_shift    sticky flag: illegal shift request seen
// ----------------------------------------------------------------------------
module cavlc_bit_window #(
  parameter int WIN_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [WORD_W-1:0]                i_word_in,
  input  logic                             i_word_valid,
  output logic                             o_word_ready,
  output logic [WIN_W-1:0]                 o_window,
  output logic                             o_window_valid,
  input  logic                             i_shift_en,
  input  logic [4:0]                       i_shift_amt,
  input  logic                             i_flush,
  input  logic                             i_align_req,
  output logic [31:0]                      o_bit_pos,
  output logic [$clog2(2*WORD_W+1)-1:0]    o_fill,
  output logic                             o_err_shift
);

  localparam int BUF_W  = 2 * WORD_W;
  localparam int FILL_W = $clog2(BUF_W + 1);

  localparam logic [FILL_W-1:0] LP_WORD = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] LP_WIN  = FILL_W'(WIN_W);

  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic [31:0]       r_bit_pos;
  logic              r_err;
  logic              r_align_pend;

  logic [2:0]        w_align_d;
  logic              w_align_act;
  logic [FILL_W-1:0] w_shift;
  logic              w_pend_nxt;
  logic              w_err_nxt;
  logic              w_window_valid;
  logic              w_word_ready;
  logic              w_load;
  logic [FILL_W-1:0] w_rem;
  logic [FILL_W-1:0] w_load_sh;
  logic [BUF_W-1:0]  w_word_ext;
  logic [BUF_W-1:0]  w_buf_nxt;
  logic [FILL_W-1:0] w_fill_nxt;

  assign w_window_valid = (r_fill >= LP_WIN);
  assign w_word_ready   = (r_fill <= LP_WORD) && !i_flush;
  assign w_load         = i_word_valid && w_word_ready;

  // Distance to the next byte boundary. The modulo-8 subtraction gives 0 when
  // the position is already aligned.
  assign w_align_d   = 3'd0 - r_bit_pos[2:0];
  assign w_align_act = i_align_req || r_align_pend;

  always_comb begin
    w_shift    = '0;
    w_pend_nxt = r_align_pend;
    w_err_nxt  = r_err;
    if (w_align_act) begin
      // An align in progress takes over the shifter. ShiftEn is silently ignored.
      if (FILL_W'(w_align_d) <= r_fill) begin
        w_shift    = FILL_W'(w_align_d);
        w_pend_nxt = 1'b0;
      end else begin
        w_pend_nxt = 1'b1;
      end
    end else if (i_shift_en) begin
      if (w_window_valid && (FILL_W'(i_shift_amt) <= LP_WIN)) begin
        w_shift = FILL_W'(i_shift_amt);
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end

  // The new word lands right after the bits that survive this cycle's shift.
  // A load only happens when Fill <= WORD_W, so w_rem <= WORD_W and the
  // placement shift stays within 0..WORD_W.
  always_comb begin
    w_rem      = r_fill - w_shift;
    w_load_sh  = LP_WORD - w_rem;
    w_word_ext = {{WORD_W{1'b0}}, i_word_in} << w_load_sh;
    w_buf_nxt  = r_buf << w_shift;
    w_fill_nxt = w_rem;
    if (w_load) begin
      w_buf_nxt  = w_buf_nxt | w_word_ext;
      w_fill_nxt = w_rem + LP_WORD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf        <= '0;
      r_fill       <= '0;
      r_bit_pos    <= '0;
      r_err        <= 1'b0;
      r_align_pend <= 1'b0;
    end else if (i_flush) begin
      // The error flag is sticky across flushes. Only reset clears it.
      r_buf        <= '0;
      r_fill       <= '0;
      r_bit_pos    <= '0;
      r_align_pend <= 1'b0;
    end else begin
      r_buf        <= w_buf_nxt;
      r_fill       <= w_fill_nxt;
      r_bit_pos    <= r_bit_pos + 32'(w_shift);
      r_err        <= w_err_nxt;
      r_align_pend <= w_pend_nxt;
    end
  end

  assign o_window       = r_buf[BUF_W-1 -: WIN_W];
  assign o_window_valid = w_window_valid;
  assign o_word_ready   = w_word_ready;
  assign o_fill         = r_fill;
  assign o_bit_pos      = r_bit_pos;
  assign o_err_shift    = r_err;

endmodule

// File: tb/tb_cavlc_bit_window.sv
module tb_cavlc_bit_window;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [15:0] window;
  logic        window_valid;
  logic        shift_en = 1'b0;
  logic [4:0]  shift_amt = '0;
  logic        flush = 1'b0;
  logic        align_req = 1'b0;
  logic [31:0] bit_pos;
  logic [6:0]  fill;
  logic        err_shift;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: the buffer is a plain queue of bits, earliest bit first.
  bit          m_q[$];
  int unsigned m_bitpos;
  bit          m_err;
  bit          m_pend;

  cavlc_bit_window #(.WIN_W(16), .WORD_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_word_in(word_in), .i_word_valid(word_valid), .o_word_ready(word_ready),
    .o_window(window), .o_window_valid(window_valid),
    .i_shift_en(shift_en), .i_shift_amt(shift_amt),
    .i_flush(flush), .i_align_req(align_req),
    .o_bit_pos(bit_pos), .o_fill(fill), .o_err_shift(err_shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_window();
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++)
      if (i < m_q.size()) w[15-i] = m_q[i];
    return w;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_bitpos = 0;
    m_err = 0;
    m_pend = 0;
  endtask

  task automatic m_clock();
    int s;
    int d;
    bit take;
    if (flush) begin
      m_q.delete();
      m_bitpos = 0;
      m_pend = 0;
      return;
    end
    take = word_valid && (m_q.size() <= 32);
    s = 0;
    if (align_req || m_pend) begin
      d = (8 - (m_bitpos % 8)) % 8;
      if (d <= m_q.size()) begin
        s = d;
        m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end else if (shift_en) begin
      if (m_q.size() >= 16 && shift_amt <= 16) s = shift_amt;
      else m_err = 1;
    end
    for (int i = 0; i < s; i++) void'(m_q.pop_front());
    m_bitpos += s;
    if (take)
      for (int i = 31; i >= 0; i--) m_q.push_back(word_in[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".window"}, 64'(window), 64'(m_window()));
    chk({tag, ".wvalid"}, 64'(window_valid), 64'(m_q.size() >= 16));
    chk({tag, ".fill"}, 64'(fill), 64'(m_q.size()));
    chk({tag, ".bitpos"}, 64'(bit_pos), 64'(m_bitpos));
    chk({tag, ".err"}, 64'(err_shift), 64'(m_err));
    chk({tag, ".ready"}, 64'(word_ready), 64'((m_q.size() <= 32) && !flush));
  endtask

  // One clock: inputs are applied now, the model advances, and the outputs
  // are checked 1 time unit after the rising edge.
  task automatic step(input string tag, input bit wv, input logic [31:0] w,
                      input bit se, input logic [4:0] amt, input bit fl, input bit al);
    word_valid = wv; word_in = w; shift_en = se; shift_amt = amt;
    flush = fl; align_req = al;
    m_clock();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    step("idle", 0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    m_reset();
    #12;
    check_all("reset");
    chk("reset.window0", 64'(window), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;

    // First word becomes visible one cycle after acceptance.
    step("load_ffff", 1, 32'hFFFF_0000, 0, 0, 0, 0);
    chk("load_ffff.win_const", 64'(window), 64'hFFFF);
    chk("load_ffff.fill_const", 64'(fill), 64'd32);

    // Two words, then shift by 5.
    step("flush1", 0, '0, 0, 0, 1, 0);
    step("load_a", 1, 32'h0123_4567, 0, 0, 0, 0);
    step("load_b", 1, 32'h89AB_CDEF, 0, 0, 0, 0);
    step("shift5", 0, '0, 1, 5'd5, 0, 0);
    chk("shift5.win_const", 64'(window), 64'h2468);
    chk("shift5.fill_const", 64'(fill), 64'd59);
    chk("shift5.ready_const", 64'(word_ready), 64'd0);

    // Shift and load in the same cycle from Fill=20.
    step("flush2", 0, '0, 0, 0, 1, 0);
    step("load_c", 1, 32'h0000_0000, 0, 0, 0, 0);
    step("shift12", 0, '0, 1, 5'd12, 0, 0);
    step("shift_load", 1, 32'hA5A5_A5A5, 1, 5'd6, 0, 0);
    chk("shift_load.fill_const", 64'(fill), 64'd46);
    chk("shift_load.win_const", 64'(window), 64'h0002);

    // Byte alignment from BitPos=13, then again when already aligned.
    step("flush3", 0, '0, 0, 0, 1, 0);
    step("load_d", 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step("shift13", 0, '0, 1, 5'd13, 0, 0);
    step("align13", 0, '0, 1, 5'd4, 0, 1);
    chk("align13.bitpos_const", 64'(bit_pos), 64'd16);
    step("align16", 0, '0, 0, 0, 0, 1);
    chk("align16.fill_const", 64'(fill), 64'd16);

    // Shift while the window is not full: error flag sets and stays set.
    step("shift6", 0, '0, 1, 5'd6, 0, 0);
    step("bad_shift", 0, '0, 1, 5'd3, 0, 0);
    chk("bad_shift.fill_const", 64'(fill), 64'd10);
    chk("bad_shift.err_const", 64'(err_shift), 64'd1);
    idle();
    step("oversize", 1, 32'h1234_5678, 0, 0, 0, 0);
    step("amt17", 0, '0, 1, 5'd17, 0, 0);

    // Flush with Fill=40 while a word is offered.
    step("flush4", 0, '0, 0, 0, 1, 0);
    step("load_e", 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    step("load_f", 1, 32'h1357_9BDF, 0, 0, 0, 0);
    step("sh16", 0, '0, 1, 5'd16, 0, 0);
    step("sh8", 0, '0, 1, 5'd8, 0, 0);
    step("flush_wv", 1, 32'hFFFF_FFFF, 0, 0, 1, 0);
    chk("flush_wv.fill_const", 64'(fill), 64'd0);
    chk("flush_wv.ready_const", 64'(word_ready), 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", $urandom_range(0, 3) != 0, $urandom(),
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 18)),
           $urandom_range(0, 60) == 0, $urandom_range(0, 12) == 0);
    end

    // Asynchronous reset mid-stream.
    step("pre_rst", 1, 32'h7777_8888, 0, 0, 0, 0);
    step("pre_rst2", 0, '0, 1, 5'd3, 0, 0);
    word_valid = 0; shift_en = 0; flush = 0; align_req = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.win_const", 64'(window), 64'h0);
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    step("post_rst", 1, 32'h8000_0001, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
